mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequencer directly upstream of the 8-to-1 4-bit data mux. It drives the mux select, waits a programmable settle time, and captures the mux output. Each captured nibble is delivered, tagged with its channel number, on a valid/ready stream to the downstream consumer. It supports single-sweep and continuous scanning over a masked subset of the 8 channels.

Parameters:
DATA_W, 4, width of the mux data path and of out_data
SEL_W, 3, select width; the number of channels is 2**SEL_W = 8
SETTLE, 2, cycles the select is held before sampling; legal range 1..15

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE
continuous  in  1  when 1 at sweep end, restart the sweep instead of returning to IDLE
abort  in  1  synchronous stop; forces IDLE on the next cycle
ch_mask  in  8  channel enable, bit i = channel i; latched when start is accepted
sel  out  SEL_W  select to the mux S input
mux_y  in  DATA_W  mux Y output
out_valid  out  1  captured sample available
out_ready  in  1  downstream accepts the sample
out_ch  out  SEL_W  channel of the current sample
out_data  out  DATA_W  captured sample
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of each sweep

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; sel, out_ch and out_data = 0; out_valid, busy and done = 0; latched mask = 0. Reset overrides start and abort.
- States:
  - IDLE
  - SETTLE: sel stable, settle counter running
  - OUT: out_valid=1, waiting for out_ready
- IDLE, start=1, ch_mask!=0: latch the mask, load sel with the lowest enabled channel, go to SETTLE. The counter loads SETTLE-1.
- IDLE, start=1, ch_mask==0: stay in IDLE and pulse done on the next cycle. No output is produced.
- SETTLE: decrement the counter each cycle. In the cycle the counter is 0:
  - capture mux_y into out_data and sel into out_ch
  - set out_valid on the next cycle and go to OUT
  - Latency: start accepted at cycle T gives sel valid from T+1 and out_valid from T+1+SETTLE.
- OUT: out_data, out_ch and out_valid are held stable until the handshake (out_valid and out_ready high in the same cycle). On the handshake cycle:
  - If a higher enabled channel exists: sel = next enabled channel (ascending, masked channels skipped), out_valid=0, go to SETTLE.
  - Else, end of sweep: done=1 next cycle.
    - If continuous=1: sel = lowest enabled channel, go to SETTLE. The latched mask is reused, not resampled.
    - If continuous=0: go to IDLE, busy=0.
- Back-to-back samples are separated by at least SETTLE cycles with out_valid=0. There is no buffering and no sample is ever dropped; out_ready low simply stalls the scan.
- sel changes only on entry to SETTLE. It holds its last value in IDLE and OUT.
- abort=1 in any state: next cycle state=IDLE, out_valid=0, busy=0, no done pulse. sel and out_* keep their values. abort beats start in the same cycle.
- Deasserting continuous mid-sweep lets the current sweep finish, then the block returns to IDLE.
- start while busy is ignored; ch_mask changes while busy are ignored.
- Single enabled channel in continuous mode: repeated samples of that channel, with done pulsing after every handshake.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SETTLE, OUT}
  - DATA_W and SEL_W defaults
  - NUM_CH = 8
  - settle counter width constant = 4
- Sub-module mux_next_ch: purely combinational. Inputs are the latched mask and the current channel. Outputs are next_ch (lowest enabled channel above current), has_next, and first_ch (lowest enabled overall).
- All state, counter and output registers stay in mux_scan_ctrl.

Test Plan:
- mask=8'hFF, SETTLE=2, out_ready=1, mux_y=channel index, start pulse at T -> sel 0..7 in order; out_valid first at T+3; out_data=out_ch for each of 8 samples; done pulses once; then IDLE.
- mask=8'b1010_0100, out_ready=1 -> samples only on channels 2, 5, 7; channels 0, 1, 3, 4, 6 never driven on sel.
- Hold out_ready=0 for 10 cycles on channel 3 while mux_y changes -> out_data and out_ch stay frozen; sel stays 3; scan resumes after the handshake.
- continuous=1, mask=8'h81 -> channel sequence 0, 7, 0, 7…; done pulses after each channel-7 handshake; clear continuous -> IDLE after the next channel-7 handshake.
- abort in SETTLE and again in OUT (with start also high) -> IDLE next cycle, out_valid=0, busy=0, no done pulse; rst_n=0 mid-sweep -> all outputs reach reset values on the next edge.
- start with mask=0 -> no out_valid, done pulse one cycle later; start asserted while busy -> ignored, sweep unchanged.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int SEL_W_DEF  = 3;
  localparam int NUM_CH     = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

endpackage

// File: rtl/mux_next_ch.sv
// Channel picker: lowest enabled channel above the current one, and the
// lowest enabled channel overall, for a given channel mask.
module mux_next_ch
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur_ch,
  output logic [SEL_W-1:0]  next_ch,
  output logic              has_next,
  output logic [SEL_W-1:0]  first_ch
);

  // Scan from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    next_ch  = '0;
    has_next = 1'b0;
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_ch = SEL_W'(i);
        if (i > int'(cur_ch)) begin
          next_ch  = SEL_W'(i);
          has_next = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps the mux select over the enabled channels,
// waits for the mux output to settle, captures it and offers it downstream.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no sweep running; sel and out_* hold their last values
//   ST_SETTLE | sel stable, down-counter running to the capture cycle
//   ST_OUT    | out_valid high, sample held until out_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // Counter reaches zero in the last settle cycle, which is the capture cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                done_q, done_d;

  logic [NUM_CH-1:0]   pick_mask;
  logic [SEL_W-1:0]    next_ch;
  logic [SEL_W-1:0]    first_ch;
  logic                has_next;

  // In IDLE the picker looks at the live mask so the first channel is ready
  // on the accepting edge; during a sweep it only sees the latched copy.
  assign pick_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;

  mux_next_ch #(
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask     (pick_mask),
    .cur_ch   (sel_q),
    .next_ch  (next_ch),
    .has_next (has_next),
    .first_ch (first_ch)
  );

  // Next-state, counter and capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    sel_d      = sel_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (ch_mask == '0) begin
              done_d = 1'b1;
            end else begin
              mask_d  = ch_mask;
              sel_d   = first_ch;
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            out_ch_d   = sel_q;
            out_data_d = mux_y;
            state_d    = ST_OUT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (has_next) begin
              sel_d   = next_ch;
              cnt_d   = CNT_LOAD;
              state_d = ST_SETTLE;
            end else begin
              done_d = 1'b1;
              if (continuous) begin
                sel_d   = first_ch;
                cnt_d   = CNT_LOAD;
                state_d = ST_SETTLE;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  assign sel       = sel_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl against a sweep-level reference model:
// each sweep is a list of enabled channels, and sample timing is derived
// from cycle timestamps (select at T+1, valid at T+1+SETTLE).
module tb_mux_scan_ctrl;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;
  localparam int SETTLE = 2;
  localparam int N_CYC  = 8000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [7:0]        ch_mask;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_y;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_ch;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] data_arr [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural 8-to-1 mux driven by the DUT select.
  assign mux_y = data_arr[sel];

  mux_scan_ctrl #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .ch_mask    (ch_mask),
    .sel        (sel),
    .mux_y      (mux_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v, input int cyc);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] pick_mask();
    case ($urandom_range(7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h01 << $urandom_range(7);
      3:       return 8'h81;
      4:       return 8'b1010_0100;
      default: return 8'($urandom());
    endcase
  endfunction

  // Reference model state: expectations for the current cycle.
  bit        act;
  int        chs[$];
  int        idx;
  longint    valid_at;
  int        e_sel, e_ch, e_data;
  bit        e_valid, e_done;
  int        stall;

  initial begin
    for (int i = 0; i < 8; i++) data_arr[i] = DATA_W'(i);
    rst_n      = 1'b0;
    start      = 1'b1;
    continuous = 1'b0;
    abort      = 1'b1;
    ch_mask    = 8'hFF;
    out_ready  = 1'b0;
    act        = 1'b0;
    idx        = 0;
    valid_at   = 0;
    e_sel      = 0;
    e_ch       = 0;
    e_data     = 0;
    e_valid    = 1'b0;
    e_done     = 1'b0;
    stall      = 0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      chk("busy",      busy,      32'(act),     cyc);
      chk("out_valid", out_valid, 32'(e_valid), cyc);
      chk("done",      done,      32'(e_done),  cyc);
      chk("sel",       sel,       32'(e_sel),   cyc);
      chk("out_ch",    out_ch,    32'(e_ch),    cyc);
      chk("out_data",  out_data,  32'(e_data),  cyc);

      // Stimulus for this cycle.
      rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(499) != 0);
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(69) == 0);
      if ($urandom_range(39) == 0) continuous = ~continuous;
      ch_mask = pick_mask();
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = ($urandom_range(3) != 0);
        if ($urandom_range(49) == 0) stall = 10;
      end
      if ($urandom_range(1) == 1) data_arr[$urandom_range(7)] = DATA_W'($urandom());

      // Advance the model to the next cycle.
      e_done = 1'b0;
      if (!rst_n) begin
        act     = 1'b0;
        e_valid = 1'b0;
        e_sel   = 0;
        e_ch    = 0;
        e_data  = 0;
      end else if (abort) begin
        act     = 1'b0;
        e_valid = 1'b0;
      end else if (!act) begin
        if (start) begin
          if (ch_mask == 8'h00) begin
            e_done = 1'b1;
          end else begin
            chs.delete();
            for (int i = 0; i < 8; i++) if (ch_mask[i]) chs.push_back(i);
            idx      = 0;
            act      = 1'b1;
            e_sel    = chs[0];
            valid_at = cyc + 1 + SETTLE;
          end
        end
      end else begin
        if (e_valid && out_ready) begin
          e_valid = 1'b0;
          idx++;
          if (idx == chs.size()) begin
            e_done = 1'b1;
            if (continuous) idx = 0;
            else act = 1'b0;
          end
          if (act) begin
            e_sel    = chs[idx];
            valid_at = cyc + 1 + SETTLE;
          end
        end else if (!e_valid && (cyc + 1 == valid_at)) begin
          e_valid = 1'b1;
          e_ch    = e_sel;
          e_data  = int'(data_arr[e_sel]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
